// File: rtl/haraka_pkg.sv
// Shared constants, FSM state type and length helper for the digest scheduler.
package haraka_pkg;

    localparam int DIGEST_W_DEF = 256;
    localparam int LEN_W        = 6;
    localparam int MAX_BYTES    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
    endfunction

endpackage

// File: rtl/sched_arbiter.sv
// Requester arbiter: round-robin with SCHED_ROUND_ROBIN_EN defined, otherwise fixed
// priority (lowest index wins) with no pointer state at all.
module sched_arbiter
    import haraka_pkg::*;
#(
    parameter int NREQ = 2
) (
`ifdef SCHED_ROUND_ROBIN_EN
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            accept_i,
`endif
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o
);

`ifdef SCHED_ROUND_ROBIN_EN
    localparam int PW = $clog2(NREQ);

    // ptr_q holds (last winner + 1) mod NREQ, i.e. where the next search starts
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (accept_i && grant_o[i]) begin
                ptr_d = PW'((i + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        logic found;
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i]) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/digest_scheduler.sv
// Serialises digests from NREQ requesters into a byte stream, MSB first.
// Arbitration policy selected by SCHED_ROUND_ROBIN_EN (default: fixed priority).
module digest_scheduler
    import haraka_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int DIGEST_W = DIGEST_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DIGEST_W-1:0] req_data,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(NREQ)-1:0]  out_src,
    output logic                     busy,
    output logic                     err_len
);

    localparam int SW = $clog2(NREQ);

    sched_state_t        state_q, state_d;
    logic [DIGEST_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic [SW-1:0]       src_q, src_d;
    logic                err_q, err_d;

    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     grant_idle;
    logic                accept;
    logic [SW-1:0]       win_idx;
    logic [DIGEST_W-1:0] sel_data;
    logic [LEN_W-1:0]    sel_len;

    sched_arbiter #(
        .NREQ     (NREQ)
    ) u_arbiter (
`ifdef SCHED_ROUND_ROBIN_EN
        .clk_i    (clk),
        .rst_ni   (reset),
        .accept_i (accept),
`endif
        .req_i    (req_valid),
        .grant_o  (grant)
    );

    assign grant_idle = (state_q == IDLE) ? grant : '0;
    assign accept     = |(req_valid & grant_idle);
    // Outputs must read zero while reset is held, even with requests pending
    assign req_ready  = grant_idle & {NREQ{reset}};

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx = SW'(i);
            end
        end
    end

    assign sel_data = req_data[int'(win_idx)*DIGEST_W +: DIGEST_W];
    assign sel_len  = req_len[int'(win_idx)*LEN_W +: LEN_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        src_d   = src_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // A zero-length digest is consumed (and arbitration advances) but emits nothing
                    if (sel_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        shreg_d = sel_data;
                        count_d = clamp_len(sel_len);
                        src_d   = win_idx;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    shreg_d = shreg_q << 8;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == SEND);
        busy      = (state_q == SEND);
        out_byte  = shreg_q[DIGEST_W-1 -: 8];
        out_last  = (state_q == SEND) && (count_q == LEN_W'(1));
        out_src   = src_q;
        err_len   = err_q;
    end

endmodule

// File: tb/tb_digest_scheduler.sv
// Self-checking bench for digest_scheduler: directed scenarios plus randomized traffic
// checked cycle by cycle against a queue-based reference model.
module tb_digest_scheduler;

    localparam int NREQ = 3;
    localparam int DW   = 256;
    localparam int LW   = 6;
    localparam int SW   = $clog2(NREQ);
    localparam int EW   = SW + 9;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ*LW-1:0] req_len = '0;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;
    logic [SW-1:0]     out_src;
    logic              busy;
    logic              err_len;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [EW-1:0] exp_q[$];
    logic          err_exp  = 1'b0;
    int            last_win = NREQ - 1;
    int            n_txn    = 0;
    int            n_bytes  = 0;
    int            n_err    = 0;
    int            win_hist[$];
    logic [7:0]    got_bytes[$];

    int   ready_mode  = 0;
    logic ready_force = 1'b1;

    logic [DW-1:0] k_data = 256'h9b26a926_0ed10123_456789ab_cdef0123_456789ab_cdef0123_456789ab_c4f34076;
    logic [7:0]    short_exp [6] = '{8'h9b, 8'h26, 8'ha9, 8'h26, 8'h0e, 8'hd1};

    always #5 clk = ~clk;

    digest_scheduler #(
        .NREQ     (NREQ),
        .DIGEST_W (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_len   (req_len),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy),
        .err_len   (err_len)
    );

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick_winner(input logic [NREQ-1:0] v, input int lw);
`ifdef SCHED_ROUND_ROBIN_EN
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(lw + k) % NREQ]) return (lw + k) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k + 0 * lw;
        end
`endif
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic load(input int i, input logic [DW-1:0] d, input int len);
        req_data[i*DW +: DW] = d;
        req_len[i*LW +: LW]  = LW'(len);
        req_valid[i]         = 1'b1;
    endtask

    // One clock cycle: sample at the falling edge, check against the model, update it,
    // then return just after the next rising edge so the caller can drive inputs.
    task automatic cycle_step();
        int              w;
        int              n;
        logic            exp_busy;
        logic [DW-1:0]   d;
        logic [LW-1:0]   len;
        logic [DW-1:0]   sh;
        @(negedge clk);
        w = -1;
        if (!reset) begin
            check_eq("reset_outputs",
                     {req_ready, out_byte, out_valid, out_last, out_src, busy, err_len}, 64'd0);
            exp_q.delete();
            err_exp  = 1'b0;
            last_win = NREQ - 1;
        end else begin
            exp_busy = (exp_q.size() != 0);
            w = exp_busy ? -1 : pick_winner(req_valid, last_win);
            check_eq("busy_valid", {out_valid, busy}, {exp_busy, exp_busy});
            check_eq("err_len", err_len, err_exp);
            check_eq("req_ready", req_ready, onehot(w));
            if (err_len) n_err++;
            if (exp_busy) begin
                check_eq("stream", {out_src, out_last, out_byte}, exp_q[0]);
                if (out_ready) begin
                    got_bytes.push_back(out_byte);
                    exp_q.delete(0);
                    n_bytes++;
                end
            end
            err_exp = 1'b0;
            if (w >= 0) begin
                d   = req_data[w*DW +: DW];
                len = req_len[w*LW +: LW];
                n   = (int'(len) > 32) ? 32 : int'(len);
                err_exp = (n == 0);
                for (int k = 0; k < n; k++) begin
                    sh = d >> (DW - 8 - 8 * k);
                    exp_q.push_back({SW'(w), (k == n - 1), sh[7:0]});
                end
                last_win = w;
                win_hist.push_back(w);
                $display("txn %0d: src=%0d len=%0d bytes=%0d", n_txn, w, len, n);
                n_txn++;
            end
        end
        @(posedge clk);
        #1;
        if (w >= 0) req_valid[w] = 1'b0;
    endtask

    task automatic run_idle(input int limit);
        int t;
        t = 0;
        do begin
            cycle_step();
            t++;
        end while ((exp_q.size() != 0 || req_valid != '0 || err_exp) && t < limit);
        check_eq("idle_reached", t < limit, 1);
    endtask

    initial begin
        int            t;
        int            base;
        int            r;
        logic [DW-1:0] d;
        int            cont_exp [3];
        int            zl_exp [3] = '{1, 0, 1};
`ifdef SCHED_ROUND_ROBIN_EN
        cont_exp = '{0, 1, 0};
`else
        cont_exp = '{0, 0, 0};
`endif
        repeat (3) cycle_step();
        reset = 1'b1;
        cycle_step();

        // Contention straight after reset: both requesters held valid
        base = win_hist.size();
        load(0, k_data, 4);
        load(1, ~k_data, 4);
        t = 0;
        while (win_hist.size() < base + 3 && t < 200) begin
            cycle_step();
            t++;
            req_valid[1:0] = 2'b11;
        end
        req_valid = '0;
        run_idle(100);
        for (int k = 0; k < 3; k++) check_eq("contention_src", win_hist[base + k], cont_exp[k]);

        // Single full-length digest
        got_bytes.delete();
        load(0, k_data, 32);
        run_idle(200);
        check_eq("single_count", got_bytes.size(), 32);
        check_eq("single_first", got_bytes[0], 8'h9b);
        check_eq("single_final", got_bytes[31], 8'h76);

        // Short length
        got_bytes.delete();
        load(0, k_data, 6);
        run_idle(100);
        check_eq("short_count", got_bytes.size(), 6);
        for (int k = 0; k < 6; k++) check_eq("short_byte", got_bytes[k], short_exp[k]);

        // Backpressure after byte 3
        got_bytes.delete();
        base = n_bytes;
        load(0, k_data, 32);
        t = 0;
        while (n_bytes < base + 3 && t < 100) begin
            cycle_step();
            t++;
        end
        ready_force = 1'b0;
        repeat (5) begin
            cycle_step();
            check_eq("bp_hold", {out_valid, out_byte}, {1'b1, 8'h26});
        end
        ready_force = 1'b1;
        run_idle(200);
        check_eq("bp_count", got_bytes.size(), 32);

        // Zero length on req1, then req0 must win next
        base = n_err;
        r    = win_hist.size();
        load(1, k_data, 0);
        cycle_step();
        load(0, k_data, 5);
        load(1, ~k_data, 5);
        run_idle(200);
        check_eq("zero_len_err_cycles", n_err - base, 1);
        for (int k = 0; k < 3; k++) check_eq("zero_len_order", win_hist[r + k], zl_exp[k]);

        // Reset in the middle of a transfer
        base = n_bytes;
        load(0, k_data, 32);
        t = 0;
        while (n_bytes < base + 10 && t < 100) begin
            cycle_step();
            t++;
        end
        load(2, ~k_data, 8);
        reset = 1'b0;
        #1;
        check_eq("reset_async",
                 {req_ready, out_byte, out_valid, out_last, out_src, busy, err_len}, 64'd0);
        repeat (3) cycle_step();
        req_valid = '0;
        reset = 1'b1;
        base = n_bytes;
        repeat (20) cycle_step();
        check_eq("post_reset_silent", n_bytes - base, 0);

        // Randomized traffic with random backpressure and out-of-range lengths
        ready_mode = 1;
        base = n_txn;
        t = 0;
        while (n_txn < base + 40 && t < 6000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
                    r = $urandom_range(0, 9);
                    load(i, d, (r == 0) ? 0 : (r == 1) ? int'($urandom_range(33, 63))
                                                       : int'($urandom_range(1, 32)));
                end
            end
            cycle_step();
            t++;
        end
        check_eq("rand_progress", n_txn >= base + 40, 1);
        req_valid = '0;
        ready_mode = 0;
        run_idle(400);
        check_eq("leftover_bytes", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digest_scheduler.md
DIGEST_SCHEDULER -- requirements
Module: digest_scheduler

Interface
REQ-001 Parameter NREQ, default 2: number of digest requesters, 2..8.
REQ-002 Parameter DIGEST_W, default 256: digest width in bits, multiple of 8.
REQ-003 Port clk  input  1: single clock; all state on rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port req_valid  input  NREQ: requester i holds a digest.
REQ-006 Port req_ready  output  NREQ: one-hot grant; digest i is accepted on the edge where req_valid[i] and req_ready[i] are both high.
REQ-007 Port req_data  input  NREQ*DIGEST_W: digest i at [i*DIGEST_W +: DIGEST_W].
REQ-008 Port req_len  input  NREQ*6: byte count i at [i*6 +: 6]; legal range 1..32.
REQ-009 Port out_byte  output  8: current serial byte.
REQ-010 Port out_valid  output  1: out_byte is valid.
REQ-011 Port out_ready  input  1: sink accepts out_byte on the edge where out_valid and out_ready are both high.
REQ-012 Port out_last  output  1: current byte is the final byte of the digest.
REQ-013 Port out_src  output  $clog2(NREQ): index of the requester being streamed.
REQ-014 Port busy  output  1: high in every state except IDLE.
REQ-015 Port err_len  output  1: one-cycle pulse when a digest with req_len==0 is accepted.

Function
REQ-016 The FSM SHALL have two states, IDLE and SEND.
REQ-017 In IDLE with any req_valid high, req_ready SHALL be asserted combinationally to the arbiter winner only.
REQ-018 req_ready SHALL be all-zero in SEND.
REQ-019 On accept with len>=1, the block SHALL capture the digest into a shift register, set count=len (values >32 clamp to 32), latch out_src, and enter SEND.
REQ-020 Latency: out_valid SHALL rise on the first cycle after the accept edge.
REQ-021 Byte order SHALL be MSB first: byte k = digest[DIGEST_W-1-8k -: 8].
REQ-022 On each out handshake, the register SHALL shift left by 8 and count SHALL decrement.
REQ-023 out_last SHALL equal (count==1) while out_valid is high.
REQ-024 With out_valid high and out_ready low, out_byte, out_last and out_src SHALL stay stable.
REQ-025 On the handshake of the last byte, the FSM SHALL return to IDLE; out_valid SHALL be low the next cycle.
REQ-026 A new grant is possible in that same next cycle, giving a one-cycle gap between digests.
REQ-027 On accept with len==0, the block SHALL pulse err_len for one cycle, emit no bytes, stay in IDLE and advance arbitration as for a served request.
REQ-028 The arbiter pointer SHALL advance only on an accepted request.
REQ-029 req_valid changes during SEND SHALL have no effect.

Reset
REQ-030 While reset is low, every output SHALL be 0, the FSM SHALL be IDLE, count 0 and arbiter pointer 0.
REQ-031 A reset asserted mid-transfer SHALL discard the digest; after release no byte of it is re-emitted.

Configuration
REQ-032 With SCHED_ROUND_ROBIN_EN defined, the arbiter SHALL be round-robin, searching from (last winner+1) mod NREQ.
REQ-033 Without SCHED_ROUND_ROBIN_EN, the arbiter SHALL be fixed-priority, lowest index wins, and the pointer logic SHALL be absent.

Structure
REQ-034 Package haraka_pkg SHALL hold DIGEST_W_DEF=256, LEN_W=6, MAX_BYTES=32 and the FSM state enum sched_state_t.
REQ-035 Arbitration SHALL live in one sub-module, sched_arbiter (inputs: request vector, accept strobe; outputs: one-hot grant).

Verification
REQ-036 Single digest: req0 with data 256'h9b26a926...c4f34076, len 32, out_ready=1 -> 32 bytes 9b,26,a9,...,40,76 on consecutive cycles; out_last only on 76; out_src=0.
REQ-037 Short length: same data, len 6 -> bytes 9b 26 a9 26 0e d1; out_last on d1; busy low the cycle after.
REQ-038 Contention (SCHED_ROUND_ROBIN_EN): req0 and req1 held valid continuously -> out_src sequence 0,1,0; without the macro the sequence is 0,0,0.
REQ-039 Backpressure: out_ready low for 5 cycles after byte 3 -> out_byte holds 26 for 5 cycles; no byte is lost or duplicated.
REQ-040 Zero length: req1 with len 0 -> err_len high exactly 1 cycle; out_valid never rises; the next grant goes to req0.
REQ-041 Reset mid-stream: reset low after byte 10 of a len-32 digest -> all outputs 0 immediately; after release with no requests, out_valid stays 0.
